// File: rtl/assoc_score_accum.sv
// assoc_score_accum
// Associative-memory score engine for the sparse HDC classifier. For one
// query it walks NUM_CLASS stored classes in order. For each class it sums
// NUM_SEG segment partial sums into a score, then compares that score with
// the running argmax. The result is the winning class index and its score,
// qualified by a one-cycle done pulse.
module assoc_score_accum #(
   parameter int SUM_W     = 10,
   parameter int SCORE_W   = 13,
   parameter int NUM_SEG   = 8,
   parameter int NUM_CLASS = 10,
   parameter bit SAT       = 1'b1,
   parameter int CLS_W     = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               start,
   input  logic               sum_valid,
   input  logic [SUM_W-1:0]   sum_input,
   output logic               in_ready,
   output logic               busy,
   output logic [SCORE_W-1:0] stored_score,
   output logic [CLS_W-1:0]   cur_class,
   output logic               score_valid,
   output logic [SCORE_W-1:0] class_score,
   output logic               done,
   output logic [CLS_W-1:0]   best_class,
   output logic [SCORE_W-1:0] best_score
);

   localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEG - 1);
   localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_CMP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state;
   logic [SEG_W-1:0]   seg_cnt;
   logic               beat;
   logic [SCORE_W-1:0] add_res;

   // The add is one bit wider than the score so the carry is visible.
   // SAT=1 clamps to all-ones on carry. Once the score is all-ones, every
   // later add carries again (or adds zero), so it stays pinned for the
   // rest of the class. SAT=0 drops the carry (modulo wrap).
   function automatic logic [SCORE_W-1:0] acc_add(input logic [SCORE_W-1:0] acc,
                                                  input logic [SUM_W-1:0]   x);
      logic [SCORE_W:0] wide;
      wide = {1'b0, acc} + {{(SCORE_W + 1 - SUM_W){1'b0}}, x};
      if (SAT && wide[SCORE_W])
         acc_add = '1;
      else
         acc_add = wide[SCORE_W-1:0];
   endfunction

   // in_ready is a registered copy of (state == ST_ACC), so it qualifies a beat directly.
   assign beat = sum_valid && in_ready;

   // Next value of the running score if the current beat is accepted.
   always_comb begin
      add_res = acc_add(stored_score, sum_input);
   end

   // Control FSM with registered outputs. Each output register changes on
   // the same edge as the state transition it belongs to.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= ST_IDLE;
         seg_cnt      <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         stored_score <= '0;
         cur_class    <= '0;
         score_valid  <= 1'b0;
         class_score  <= '0;
         done         <= 1'b0;
         best_class   <= '0;
         best_score   <= '0;
      end else begin
         score_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_ACC;
                  in_ready     <= 1'b1;
                  busy         <= 1'b1;
                  stored_score <= '0;
                  seg_cnt      <= '0;
                  cur_class    <= '0;
                  best_class   <= '0;
                  best_score   <= '0;
               end
            end
            ST_ACC: begin
               if (beat) begin
                  stored_score <= add_res;
                  if (seg_cnt == SEG_LAST) begin
                     // Last segment of this class: present the finished score next cycle.
                     state       <= ST_CMP;
                     in_ready    <= 1'b0;
                     score_valid <= 1'b1;
                     class_score <= add_res;
                  end else begin
                     seg_cnt <= seg_cnt + SEG_W'(1);
                  end
               end
            end
            ST_CMP: begin
               // Strict compare: on a tie the lower index wins. Class 0 always seeds the argmax.
               if ((cur_class == '0) || (stored_score > best_score)) begin
                  best_class <= cur_class;
                  best_score <= stored_score;
               end
               if (cur_class == CLS_LAST) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  state        <= ST_ACC;
                  in_ready     <= 1'b1;
                  cur_class    <= cur_class + CLS_W'(1);
                  stored_score <= '0;
                  seg_cnt      <= '0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_assoc_score_accum.sv
// Testbench for assoc_score_accum: a main instance (4 classes x 3 segments)
// plus two saturation instances (11-bit score, 4 segments, SAT=1 / SAT=0).
module tb_assoc_score_accum;

   localparam int NS  = 3;
   localparam int NC  = 4;
   localparam int SW  = 10;
   localparam int CW  = 13;
   localparam int CLW = 2;
   localparam int SNS = 4;
   localparam int SNC = 2;
   localparam int SCW = 11;
   localparam int LIMIT = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic nrst;

   logic           start, sum_valid;
   logic [SW-1:0]  sum_input;
   logic           in_ready, busy, score_valid, done;
   logic [CW-1:0]  stored_score, class_score, best_score;
   logic [CLW-1:0] cur_class, best_class;

   logic           s_start, s_valid;
   logic [SW-1:0]  s_input;
   logic           a_in_ready, a_busy, a_score_valid, a_done;
   logic [SCW-1:0] a_stored, a_class_score, a_best_score;
   logic           a_cur_class, a_best_class;
   logic           b_in_ready, b_busy, b_score_valid, b_done;
   logic [SCW-1:0] b_stored, b_class_score, b_best_score;
   logic           b_cur_class, b_best_class;

   int n_cmp  = 0;
   int n_fail = 0;
   int sums [NC][NS];

   assoc_score_accum #(.SUM_W(SW), .SCORE_W(CW), .NUM_SEG(NS), .NUM_CLASS(NC), .SAT(1'b1)) u_main (
      .clk(clk), .nrst(nrst), .start(start), .sum_valid(sum_valid), .sum_input(sum_input),
      .in_ready(in_ready), .busy(busy), .stored_score(stored_score), .cur_class(cur_class),
      .score_valid(score_valid), .class_score(class_score), .done(done),
      .best_class(best_class), .best_score(best_score));

   assoc_score_accum #(.SUM_W(SW), .SCORE_W(SCW), .NUM_SEG(SNS), .NUM_CLASS(SNC), .SAT(1'b1)) u_sat1 (
      .clk(clk), .nrst(nrst), .start(s_start), .sum_valid(s_valid), .sum_input(s_input),
      .in_ready(a_in_ready), .busy(a_busy), .stored_score(a_stored), .cur_class(a_cur_class),
      .score_valid(a_score_valid), .class_score(a_class_score), .done(a_done),
      .best_class(a_best_class), .best_score(a_best_score));

   assoc_score_accum #(.SUM_W(SW), .SCORE_W(SCW), .NUM_SEG(SNS), .NUM_CLASS(SNC), .SAT(1'b0)) u_sat0 (
      .clk(clk), .nrst(nrst), .start(s_start), .sum_valid(s_valid), .sum_input(s_input),
      .in_ready(b_in_ready), .busy(b_busy), .stored_score(b_stored), .cur_class(b_cur_class),
      .score_valid(b_score_valid), .class_score(b_class_score), .done(b_done),
      .best_class(b_best_class), .best_score(b_best_score));

   // Score of a class from its plain integer total.
   function automatic int model_score(input int total, input int w, input bit sat);
      int lim;
      lim = 1 << w;
      if (sat) return (total > lim - 1) ? lim - 1 : total;
      return total % lim;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Random sums; some classes copy the previous one to create ties.
   task automatic fill_random();
      for (int c = 0; c < NC; c++)
         for (int s = 0; s < NS; s++)
            sums[c][s] = (c > 0 && $urandom_range(0, 3) == 0) ? sums[c-1][s] : int'($urandom_range(0, 1023));
   endtask

   // One query on the main instance. Must be entered in an IDLE cycle (posedge + 1).
   task automatic run_query(input string name, input int gap_pct, input bit spam,
                            input bit start_noise, input bit check_latency);
      int exp_sc [NC];
      int best_i, best_s, total, b, k, cyc, run;
      bit got_done;
      for (int c = 0; c < NC; c++) begin
         total = 0;
         for (int s = 0; s < NS; s++) total += sums[c][s];
         exp_sc[c] = model_score(total, CW, 1'b1);
      end
      best_i = 0;
      best_s = exp_sc[0];
      for (int c = 1; c < NC; c++)
         if (exp_sc[c] > best_s) begin best_i = c; best_s = exp_sc[c]; end

      start = 1'b1;
      sum_valid = 1'b0;
      step();
      start = 1'b0;
      cyc = 1; b = 0; k = 0; run = 0; got_done = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || best_class !== '0 || best_score !== '0 || cur_class !== '0) begin
         n_fail++;
         $display("FAIL %s start_clear: in_ready=%0d busy=%0d best_class=%0d best_score=%0d cur_class=%0d, want 1 1 0 0 0",
                  name, in_ready, busy, best_class, best_score, cur_class);
      end
      while (!got_done && cyc < LIMIT) begin
         n_cmp++;
         if (stored_score !== CW'(run) || busy !== 1'b1 || in_ready !== !(score_valid || done)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: stored_score=%0d want %0d busy=%0d in_ready=%0d sv=%0d done=%0d",
                     name, cyc, stored_score, run, busy, in_ready, score_valid, done);
         end
         if (score_valid === 1'b1) begin
            n_cmp++;
            if (k >= NC || class_score !== CW'(exp_sc[k]) || cur_class !== CLW'(k)) begin
               n_fail++;
               $display("FAIL %s class_score #%0d: got score %0d class %0d, want score %0d class %0d",
                        name, k, class_score, cur_class, (k < NC) ? exp_sc[k] : -1, k);
            end
            k++;
            if (k < NC) run = 0;
         end
         if (done === 1'b1) begin
            got_done = 1'b1;
            n_cmp++;
            if (best_class !== CLW'(best_i) || best_score !== CW'(best_s) || k !== NC ||
                (check_latency && cyc !== NC * (NS + 1) + 1)) begin
               n_fail++;
               $display("FAIL %s done: best_class=%0d best_score=%0d classes=%0d cycle=%0d, want %0d %0d %0d %0d",
                        name, best_class, best_score, k, cyc, best_i, best_s, NC, NC * (NS + 1) + 1);
            end
         end
         if (!got_done) begin
            start = start_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            sum_valid = 1'b0;
            if (spam && score_valid === 1'b1) begin
               sum_valid = 1'b1;
               sum_input = SW'($urandom);
            end else if (b < NC * NS && $urandom_range(0, 99) >= gap_pct) begin
               sum_valid = 1'b1;
               sum_input = SW'(sums[b / NS][b % NS]);
               if (in_ready === 1'b1) begin
                  run = model_score(run + sums[b / NS][b % NS], CW, 1'b1);
                  b++;
               end
            end
            step();
            cyc++;
         end
      end
      start = 1'b0;
      if (!got_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: no done after %0d cycles, want done", name, cyc);
         sum_valid = 1'b0;
      end else begin
         sum_valid = spam;
         sum_input = SW'($urandom);
         step();
         sum_valid = 1'b0;
         n_cmp++;
         if (busy !== 1'b0 || done !== 1'b0 || score_valid !== 1'b0 || in_ready !== 1'b0 ||
             best_class !== CLW'(best_i) || best_score !== CW'(best_s) || stored_score !== CW'(run)) begin
            n_fail++;
            $display("FAIL %s idle_hold: busy=%0d done=%0d best=%0d/%0d stored=%0d, want 0 0 %0d/%0d %0d",
                     name, busy, done, best_class, best_score, stored_score, best_i, best_s, run);
         end
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (in_ready !== 0 || busy !== 0 || stored_score !== 0 || cur_class !== 0 || score_valid !== 0 ||
          class_score !== 0 || done !== 0 || best_class !== 0 || best_score !== 0 ||
          a_busy !== 0 || a_stored !== 0 || a_best_score !== 0 || b_busy !== 0 || b_class_score !== 0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%0d stored=%0d best=%0d/%0d class_score=%0d, want all 0",
                  busy, stored_score, best_class, best_score, class_score);
      end
   endtask

   task automatic test_basic();
      for (int s = 0; s < NS; s++) begin
         sums[0][s] = 10; sums[1][s] = 30; sums[2][s] = 20; sums[3][s] = 15;
      end
      run_query("basic", 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_tie();
      sums[0][0] = 20; sums[0][1] = 20; sums[0][2] = 10;
      sums[1][0] = 30; sums[1][1] = 20; sums[1][2] = 20;
      sums[2][0] = 10; sums[2][1] = 30; sums[2][2] = 30;
      sums[3][0] = 5;  sums[3][1] = 5;  sums[3][2] = 0;
      run_query("tie", 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_start_busy();
      fill_random();
      run_query("start_busy", 0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int q = 0; q < 6; q++) begin
         fill_random();
         run_query("backpressure", 40, 1'b1, 1'b0, 1'b0);
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic test_back_to_back();
      for (int q = 0; q < 3; q++) begin
         fill_random();
         run_query("back_to_back", 0, 1'b1, 1'b0, 1'b1);
      end
   endtask

   task automatic test_saturation();
      int pulses, cyc, exp1, exp0;
      bit got_done;
      exp1 = model_score(SNS * 1023, SCW, 1'b1);
      exp0 = model_score(SNS * 1023, SCW, 1'b0);
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      s_valid = 1'b1;
      s_input = SW'(1023);
      pulses = 0; cyc = 0; got_done = 1'b0;
      while (!got_done && cyc < 200) begin
         if (a_score_valid === 1'b1 || b_score_valid === 1'b1) begin
            pulses++;
            n_cmp++;
            if (a_class_score !== SCW'(exp1) || b_class_score !== SCW'(exp0) || a_score_valid !== b_score_valid) begin
               n_fail++;
               $display("FAIL saturation class_score: sat1=%0d sat0=%0d, want %0d %0d",
                        a_class_score, b_class_score, exp1, exp0);
            end
         end
         if (a_done === 1'b1 || b_done === 1'b1) begin
            got_done = 1'b1;
            n_cmp++;
            if (a_best_score !== SCW'(exp1) || b_best_score !== SCW'(exp0) || a_best_class !== 1'b0 ||
                b_best_class !== 1'b0 || pulses !== SNC || a_done !== b_done) begin
               n_fail++;
               $display("FAIL saturation best: sat1=%0d/%0d sat0=%0d/%0d pulses=%0d, want 0/%0d 0/%0d %0d",
                        a_best_class, a_best_score, b_best_class, b_best_score, pulses, exp1, exp0, SNC);
            end
         end else begin
            step();
            cyc++;
         end
      end
      s_valid = 1'b0;
      if (!got_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL saturation timeout: no done after %0d cycles, want done", cyc);
      end
      step();
   endtask

   task automatic test_reset_mid_query();
      int b, guard;
      bit bad;
      fill_random();
      start = 1'b1;
      step();
      start = 1'b0;
      b = 0; guard = 0;
      while (b < 2 * NS + 1 && guard < 100) begin
         sum_valid = 1'b1;
         sum_input = SW'(sums[b / NS][b % NS]);
         if (in_ready === 1'b1) b++;
         step();
         guard++;
      end
      n_cmp++;
      if (guard >= 100 || cur_class !== CLW'(2)) begin
         n_fail++;
         $display("FAIL reset_mid setup: cur_class=%0d beats=%0d, want class 2 beats %0d", cur_class, b, 2 * NS + 1);
      end
      nrst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (busy !== 0 || in_ready !== 0 || stored_score !== 0 || cur_class !== 0 || done !== 0 ||
             score_valid !== 0 || best_class !== 0 || best_score !== 0 || class_score !== 0) begin
            n_fail++;
            $display("FAIL reset_mid cycle %0d: busy=%0d stored=%0d cur_class=%0d best=%0d/%0d, want all 0",
                     i, busy, stored_score, cur_class, best_class, best_score);
         end
      end
      nrst = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done !== 0 || score_valid !== 0 || busy !== 0 || in_ready !== 0 || stored_score !== 0) bad = 1'b1;
      end
      sum_valid = 1'b0;
      n_cmp++;
      if (bad) begin
         n_fail++;
         $display("FAIL reset_mid after: activity seen after reset (busy=%0d stored=%0d), want idle and quiet",
                  busy, stored_score);
      end
   endtask

   initial begin
      nrst = 1'b0;
      start = 1'b0; sum_valid = 1'b0; sum_input = '0;
      s_start = 1'b0; s_valid = 1'b0; s_input = '0;
      repeat (2) step();
      test_reset();
      nrst = 1'b1;
      step();
      test_basic();
      test_tie();
      test_start_busy();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      test_reset_mid_query();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
